// File: rtl/branch_predict_unit.sv
// branch_predict_unit: EX-stage branch resolution with a PC-indexed 2-bit BHT
// feeding fetch predictions, misprediction flagging and saturating perf counters.
module branch_predict_unit #(
    parameter int ADDR_W    = 32,
    parameter int BHT_DEPTH = 64,
    parameter int IDX_W     = $clog2(BHT_DEPTH),
    parameter bit DYNAMIC   = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_fetch_pc,
    output logic              o_pred_taken,
    input  logic              i_valid,
    input  logic              i_stall,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [1:0]        i_relation,
    input  logic [2:0]        i_branch,
    input  logic              i_pred_taken,
    output logic              o_branch,
    output logic              o_mispredict,
    input  logic              i_clr_cnt,
    output logic [CNT_W-1:0]  o_br_cnt,
    output logic [CNT_W-1:0]  o_miss_cnt
);
    logic is_cond, cond_true, taken, update;
    logic unused_pc;

    always_comb begin
        is_cond   = i_valid && i_branch != 3'd0 && i_branch < 3'd6 && i_relation != 2'b11;
        cond_true = (i_branch == 3'd1) ? i_relation == 2'b01 :
                    (i_branch == 3'd2) ? i_relation != 2'b01 :
                    (i_branch == 3'd3) ? i_relation != 2'b10 :
                    (i_branch == 3'd4) ? i_relation == 2'b10 :
                                         i_relation == 2'b00;
        taken     = is_cond && cond_true;
        update    = is_cond && !i_stall;
    end

    assign o_branch     = i_rst_n && taken;
    assign o_mispredict = is_cond && (o_branch != i_pred_taken);
    assign unused_pc    = ^{i_fetch_pc, i_pc};

    if (DYNAMIC) begin : g_bht
        logic [1:0]       bht [BHT_DEPTH];
        logic [IDX_W-1:0] fidx, eidx;
        assign fidx = i_fetch_pc[IDX_W+1:2];
        assign eidx = i_pc[IDX_W+1:2];
        // Read port is the pre-edge array value: no write-through bypass.
        assign o_pred_taken = i_rst_n && bht[fidx][1];
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                for (int k = 0; k < BHT_DEPTH; k++) bht[k] <= 2'b01;
            end else if (update) begin
                bht[eidx] <= taken ? ((bht[eidx] == 2'b11) ? 2'b11 : bht[eidx] + 2'd1)
                                   : ((bht[eidx] == 2'b00) ? 2'b00 : bht[eidx] - 2'd1);
            end
        end
    end else begin : g_static
        assign o_pred_taken = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_br_cnt   <= '0;
            o_miss_cnt <= '0;
        end else if (i_clr_cnt) begin
            o_br_cnt   <= '0;
            o_miss_cnt <= '0;
        end else if (update) begin
            o_br_cnt   <= o_br_cnt + CNT_W'(~&o_br_cnt);
            o_miss_cnt <= o_miss_cnt + CNT_W'(o_mispredict && ~&o_miss_cnt);
        end
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed checks of resolution, BHT training and perf
// counters on a default, a static-mode and a 4-bit-counter instance.
module tb_branch_predict_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] fetch_pc = '0, pc = '0;
    logic        valid = 1'b0, stall = 1'b0, pred = 1'b0, clr = 1'b0;
    logic [1:0]  relation = '0;
    logic [2:0]  branch = '0;

    logic        pred_t, br_o, mis_o;
    logic [15:0] br_cnt, miss_cnt;
    logic        s_pred_t, s_br_o, s_mis_o;
    logic [15:0] s_br_cnt, s_miss_cnt;
    logic        m_pred_t, m_br_o, m_mis_o;
    logic [3:0]  m_br_cnt, m_miss_cnt;

    int n_cmp = 0, n_err = 0;
    logic [3:0] tbl [8] = '{4'b0000, 4'b0010, 4'b0101, 4'b0011, 4'b0100, 4'b0001, 4'b0000, 4'b0000};

    always #5 clk = ~clk;

    branch_predict_unit dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_fetch_pc(fetch_pc), .o_pred_taken(pred_t),
        .i_valid(valid), .i_stall(stall), .i_pc(pc), .i_relation(relation),
        .i_branch(branch), .i_pred_taken(pred), .o_branch(br_o), .o_mispredict(mis_o),
        .i_clr_cnt(clr), .o_br_cnt(br_cnt), .o_miss_cnt(miss_cnt)
    );

    branch_predict_unit #(.DYNAMIC(1'b0)) dut_s (
        .i_clk(clk), .i_rst_n(rst_n), .i_fetch_pc(fetch_pc), .o_pred_taken(s_pred_t),
        .i_valid(valid), .i_stall(stall), .i_pc(pc), .i_relation(relation),
        .i_branch(branch), .i_pred_taken(pred), .o_branch(s_br_o), .o_mispredict(s_mis_o),
        .i_clr_cnt(clr), .o_br_cnt(s_br_cnt), .o_miss_cnt(s_miss_cnt)
    );

    branch_predict_unit #(.CNT_W(4)) dut_m (
        .i_clk(clk), .i_rst_n(rst_n), .i_fetch_pc(fetch_pc), .o_pred_taken(m_pred_t),
        .i_valid(valid), .i_stall(stall), .i_pc(pc), .i_relation(relation),
        .i_branch(branch), .i_pred_taken(pred), .o_branch(m_br_o), .o_mispredict(m_mis_o),
        .i_clr_cnt(clr), .o_br_cnt(m_br_cnt), .o_miss_cnt(m_miss_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic br(input logic [2:0] t, input logic [1:0] r, input logic [31:0] p, input logic pd);
        valid = 1'b1; branch = t; relation = r; pc = p; pred = pd;
    endtask

    task automatic idle();
        valid = 1'b0; branch = 3'd0; relation = 2'b00;
    endtask

    initial begin
        step(); step();
        rst_n = 1'b1;
        step();
        check("rst_br_cnt", br_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);
        for (int i = 0; i < 4; i++) begin
            fetch_pc = 32'h40 * i + 32'h4;
            #1 check("rst_pred", pred_t, 0);
        end

        fetch_pc = 32'h40;
        br(3'd1, 2'b01, 32'h40, 1'b0);
        #1;
        check("train_branch", br_o, 1);
        check("train_mis", mis_o, 1);
        check("train_pred0", pred_t, 0);
        step();
        check("train_pred1", pred_t, 1);
        check("train_br1", br_cnt, 1);
        step();
        br(3'd2, 2'b01, 32'h40, 1'b1);
        #1;
        check("nt_branch", br_o, 0);
        check("nt_mis", mis_o, 1);
        step();
        idle();
        check("train_sat11", pred_t, 1);
        check("train_br3", br_cnt, 3);
        check("train_miss3", miss_cnt, 3);

        #2;
        rst_n = 1'b0;
        br(3'd1, 2'b01, 32'h40, 1'b0);
        #1;
        check("mid_rst_br", br_cnt, 0);
        check("mid_rst_miss", miss_cnt, 0);
        check("mid_rst_pred", pred_t, 0);
        check("mid_rst_obranch", br_o, 0);
        idle();
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_pred", pred_t, 0);

        fetch_pc = 32'h80;
        for (int i = 0; i < 3; i++) begin
            br(3'd2, 2'b01, 32'h80, 1'b0);
            step();
        end
        idle();
        check("sat_low_pred", pred_t, 0);
        br(3'd4, 2'b10, 32'h80, 1'b0);
        step();
        idle();
        check("sat_up_once", pred_t, 0);
        br(3'd4, 2'b10, 32'h80, 1'b0);
        step();
        idle();
        check("sat_up_twice", pred_t, 1);
        check("sat_br5", br_cnt, 5);
        check("sat_miss2", miss_cnt, 2);

        stall = 1'b1;
        for (int t = 0; t < 8; t++) begin
            for (int r = 0; r < 4; r++) begin
                br(3'(t), 2'(r), 32'h200, 1'b0);
                #1;
                check($sformatf("dec_b%0d_r%0d", t, r), br_o, tbl[t][r]);
                check($sformatf("dec_m%0d_r%0d", t, r), mis_o, tbl[t][r]);
            end
        end
        br(3'd1, 2'b01, 32'h200, 1'b0);
        valid = 1'b0;
        #1 check("dec_invalid", br_o, 0);
        step();
        stall = 1'b0;
        check("dec_stall_br", br_cnt, 5);

        br(3'd6, 2'b00, 32'h80, 1'b0);
        #1 check("none_branch", br_o, 0);
        step();
        check("none_br_cnt", br_cnt, 5);
        br(3'd1, 2'b11, 32'h80, 1'b0);
        #1 check("rel11_branch", br_o, 0);
        check("rel11_mis", mis_o, 0);
        step();
        idle();
        check("rel11_bht", pred_t, 1);
        check("rel11_br_cnt", br_cnt, 5);

        br(3'd1, 2'b01, 32'hC0, 1'b1);
        stall = 1'b1;
        step(); step(); step();
        check("stall_frozen", br_cnt, 5);
        stall = 1'b0;
        step();
        idle();
        check("stall_once_br", br_cnt, 6);
        check("stall_once_miss", miss_cnt, 2);

        br(3'd2, 2'b01, 32'hC4, 1'b1);
        clr = 1'b1;
        #1 check("clr_mis", mis_o, 1);
        step();
        clr = 1'b0;
        idle();
        check("clr_br", br_cnt, 0);
        check("clr_miss", miss_cnt, 0);
        check("clr_bht_kept", pred_t, 1);

        fetch_pc = 32'h40;
        br(3'd1, 2'b01, 32'h40, 1'b0);
        #1 check("same_idx_old", pred_t, 0);
        step();
        idle();
        check("same_idx_new", pred_t, 1);

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        fetch_pc = 32'h100;
        for (int i = 0; i < 20; i++) begin
            br(3'd1, 2'b01, 32'h100, 1'b0);
            step();
            if (i == 9) begin
                check("static_pred", s_pred_t, 0);
                check("static_miss10", s_miss_cnt, 10);
                check("static_br10", s_br_cnt, 10);
                check("dyn_pred_trained", pred_t, 1);
            end
        end
        idle();
        check("small_br_sat", m_br_cnt, 15);
        check("small_miss_sat", m_miss_cnt, 15);
        check("big_br20", br_cnt, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised successor to the combinational branch decision logic. It still resolves branch conditions in EX from the comparator relation code. It adds a PC-indexed branch history table of 2-bit saturating counters that feeds a taken prediction to IF. It flags mispredictions against the prediction carried down the pipe and keeps saturating performance counters.

## Interface
Parameters:
- ADDR_W, 32, PC width.
- BHT_DEPTH, 64, number of BHT entries; power of two, ≥ 2.
- IDX_W, log2(BHT_DEPTH), index width.
- DYNAMIC, 1, 1 = BHT prediction; 0 = static not-taken, BHT neither read nor written.
- CNT_W, 16, performance counter width.

Ports (one clock; reset is asynchronous and active-low):
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_fetch_pc  in  ADDR_W  IF-stage PC.
- o_pred_taken  out  1  prediction for i_fetch_pc.
- i_valid  in  1  EX-stage instruction valid.
- i_stall  in  1  EX stalled; suppresses all state updates.
- i_pc  in  ADDR_W  EX-stage PC.
- i_relation  in  2  comparison result: 00 <, 01 =, 10 >, 11 invalid.
- i_branch  in  3  branch type: 000 none, 001 beq, 010 bne, 011 blez, 100 bgtz, 101 bltz, 110/111 none.
- i_pred_taken  in  1  prediction made at fetch, piped to EX.
- o_branch  out  1  resolved taken.
- o_mispredict  out  1  resolved outcome differs from i_pred_taken.
- i_clr_cnt  in  1  synchronous clear of performance counters.
- o_br_cnt  out  CNT_W  resolved conditional branches.
- o_miss_cnt  out  CNT_W  mispredictions.

## Operation
- **Conditional branch:** i_valid=1, i_branch ∈ {001..101}, i_relation ≠ 11.
- **Taken conditions:**
  - beq: rel==01.
  - bne: rel!=01.
  - blez: rel!=10.
  - bgtz: rel==10.
  - bltz: rel==00.
- **o_branch:** combinational; 1 only for a conditional branch whose condition holds, else 0. Types 000/110/111, relation 11 or i_valid=0 give 0.
- **o_mispredict:** combinational. Equals (o_branch != i_pred_taken) for a conditional branch; else 0. i_stall does not mask it.
- **BHT index:** pc[IDX_W+1:2], for both fetch and EX PCs. Aliasing is permitted.
- **o_pred_taken:** combinational. Equals bit 1 of the counter at the fetch index when DYNAMIC=1; constant 0 when DYNAMIC=0.
- **Counter encoding:** 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- **BHT update** (rising edge; conditional branch, i_stall=0, DYNAMIC=1): taken → counter+1, saturating at 11; not taken → counter−1, saturating at 00.
- **Performance counters** (update on a conditional branch with i_stall=0):
  - o_br_cnt += 1.
  - o_miss_cnt += 1 when o_mispredict=1.
  - Both saturate at all-ones and never wrap.
  - i_clr_cnt=1 zeroes both and takes priority over a simultaneous increment.
  - i_clr_cnt does not affect the BHT.

## Timing
- **Reset** (asynchronous, immediate, also mid-operation):
  - All BHT entries → 01.
  - o_br_cnt = o_miss_cnt = 0.
  - o_pred_taken = 0 and o_branch = 0 for all inputs while reset is held.
  - o_mispredict follows its combinational definition.
- **Resolution latency:** o_branch and o_mispredict are zero-latency, valid in the same cycle as the EX inputs.
- **Update latency:** BHT and counter updates are visible the cycle after the qualifying edge.
- **Same-index read/write:** when i_fetch_pc and i_pc hit the same index in one cycle, o_pred_taken shows the pre-update value. No bypass.
- **Stall:** i_stall=1 freezes BHT and counters. A branch held for N stalled cycles then released updates exactly once.

## Test plan
- **Reset:** assert i_rst_n=0 mid-run → o_br_cnt=0, o_miss_cnt=0 immediately. After release, o_pred_taken=0 for every fetch PC (all entries 01).
- **Training:** beq at pc 0x40, rel=01, i_pred_taken=0, twice → first resolution o_mispredict=1. After the first edge, fetch 0x40 gives o_pred_taken=1; after the second, the entry is 11. o_br_cnt=2, o_miss_cnt=2.
- **Saturation:** bne with rel=01 (not taken) at pc 0x80 three times from reset → entry 00, no underflow. Then bgtz rel=10 once → entry 01, o_pred_taken=0.
- **Decode coverage:**
  - Each type against each relation gives the taken conditions listed in Operation.
  - i_branch=110 with rel=00 → o_branch=0, no counter change.
  - rel=11 with beq → o_branch=0, no update.
- **Stall, clear, same-index:**
  - A taken branch held with i_stall=1 for 3 cycles, then released → o_br_cnt +1 total.
  - i_clr_cnt together with a mispredicting branch → both counters read 0 next cycle.
  - Same-index fetch during update → old prediction shown.
- **Static mode and counter saturation:**
  - DYNAMIC=0: 10 taken branches at one PC → o_pred_taken stays 0, o_miss_cnt=10.
  - CNT_W=4: 20 branches → o_br_cnt=15.
